// File: rtl/mod_147_hb_timers_pkg.sv
// ============================================================================
// mod_147_hb_timers_pkg
// Shared timer state encoding, default durations and heartbeat commands.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mod_147_hb_timers_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE    = 2'b00,
    TMR_RUNNING = 2'b01,
    TMR_EXPIRED = 2'b10
  } tmr_state_e;

  localparam int unsigned C_CNT_W_DEF                = 24;
  localparam int unsigned C_HB_TIMER_CYCLES_DEF      = 10000000;
  localparam int unsigned C_HB_SEND_TIMER_CYCLES_DEF = 2500;

  typedef enum logic [1:0] {
    NONE      = 2'b00,
    BEACON    = 2'b01,
    COMMIT    = 2'b10,
    HEARTBEAT = 2'b11
  } hb_cmd_e;

endpackage

`default_nettype wire

// File: rtl/mod_147_hb_timers_hb_timer_core.sv
// ============================================================================
// hb_timer_core
// One restartable down-counting timer with 802.3 done semantics.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hb_timer_core
  import mod_147_hb_timers_pkg::*;
#(
  parameter int unsigned CNT_W    = C_CNT_W_DEF,
  parameter int unsigned DURATION = C_HB_SEND_TIMER_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic start,
  output logic done,
  output logic running
);

  localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(DURATION - 1);

  tmr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TMR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear beats start; start beats a same-cycle natural expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = TMR_IDLE;
      cnt_d   = '0;
    end else if (start) begin
      state_d = TMR_RUNNING;
      cnt_d   = C_RELOAD;
    end else begin
      case (state_q)
        TMR_RUNNING: begin
          if (cnt_q == '0) begin
            state_d = TMR_EXPIRED;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        TMR_EXPIRED: state_d = TMR_EXPIRED;
        default:     state_d = TMR_IDLE;
      endcase
    end
  end

  // Masking with start keeps a same-cycle starter from seeing a stale done.
  assign done    = (state_q == TMR_EXPIRED) && !start;
  assign running = (state_q == TMR_RUNNING);

endmodule

`default_nettype wire

// File: rtl/mod_147_hb_timers.sv
// ============================================================================
// mod_147_hb_timers
// hb_timer and hb_send_timer for the 802.3cg heartbeat state machine.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mod_147_hb_timers
  import mod_147_hb_timers_pkg::*;
#(
  parameter int unsigned CNT_W                = C_CNT_W_DEF,
  parameter int unsigned HB_TIMER_CYCLES      = C_HB_TIMER_CYCLES_DEF,
  parameter int unsigned HB_SEND_TIMER_CYCLES = C_HB_SEND_TIMER_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic timers_clear,
  input  logic start_hb_timer,
  input  logic start_hb_send_timer,
  output logic hb_timer_done,
  output logic hb_send_timer_done,
  output logic hb_timer_running,
  output logic hb_send_timer_running
);

  localparam longint unsigned C_CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if ((HB_TIMER_CYCLES == 0) || (64'(HB_TIMER_CYCLES) > C_CNT_MAX)) begin : g_bad_hb_timer
    $error("HB_TIMER_CYCLES out of range 1..2^CNT_W-1");
  end

  if ((HB_SEND_TIMER_CYCLES == 0) || (64'(HB_SEND_TIMER_CYCLES) > C_CNT_MAX)) begin : g_bad_hb_send_timer
    $error("HB_SEND_TIMER_CYCLES out of range 1..2^CNT_W-1");
  end

  hb_timer_core #(
    .CNT_W    (CNT_W),
    .DURATION (HB_TIMER_CYCLES)
  ) u_hb_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timers_clear),
    .start   (start_hb_timer),
    .done    (hb_timer_done),
    .running (hb_timer_running)
  );

  hb_timer_core #(
    .CNT_W    (CNT_W),
    .DURATION (HB_SEND_TIMER_CYCLES)
  ) u_hb_send_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timers_clear),
    .start   (start_hb_send_timer),
    .done    (hb_send_timer_done),
    .running (hb_send_timer_running)
  );

endmodule

`default_nettype wire

// File: tb/tb_mod_147_hb_timers.sv
// ============================================================================
// tb_mod_147_hb_timers
// Scenario bench for mod_147_hb_timers with short timer durations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mod_147_hb_timers;

  localparam int unsigned C_HB = 20;
  localparam int unsigned C_SD = 5;

  logic clk = 1'b0;
  logic reset;
  logic timers_clear;
  logic start_hb_timer;
  logic start_hb_send_timer;
  logic hb_timer_done;
  logic hb_send_timer_done;
  logic hb_timer_running;
  logic hb_send_timer_running;

  // {hb_done, send_done, hb_running, send_running}
  typedef logic [3:0] exp_t;
  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;

  mod_147_hb_timers #(
    .CNT_W                (8),
    .HB_TIMER_CYCLES      (C_HB),
    .HB_SEND_TIMER_CYCLES (C_SD)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .timers_clear          (timers_clear),
    .start_hb_timer        (start_hb_timer),
    .start_hb_send_timer   (start_hb_send_timer),
    .hb_timer_done         (hb_timer_done),
    .hb_send_timer_done    (hb_send_timer_done),
    .hb_timer_running      (hb_timer_running),
    .hb_send_timer_running (hb_send_timer_running)
  );

  always #5 clk = ~clk;

  function automatic exp_t observed();
    return {hb_timer_done, hb_send_timer_done, hb_timer_running, hb_send_timer_running};
  endfunction

  // Drive inputs for the next edge, take the edge, then drop the pulses.
  task automatic cycle(input logic s_hb, input logic s_sd, input logic clr);
    start_hb_timer      = s_hb;
    start_hb_send_timer = s_sd;
    timers_clear        = clr;
    @(posedge clk);
    #1;
    start_hb_timer      = 1'b0;
    start_hb_send_timer = 1'b0;
    timers_clear        = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got;
    reset               = 1'b0;
    timers_clear        = 1'b0;
    start_hb_timer      = 1'b0;
    start_hb_send_timer = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    got = observed();
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: got %b expected 0000", got);
    end
    start_hb_timer      = 1'b1;
    start_hb_send_timer = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    got = observed();
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held_with_start: got %b expected 0000", got);
    end
    start_hb_timer      = 1'b0;
    start_hb_send_timer = 1'b0;
    #1;
    reset = 1'b0;
    for (int e = 0; e < 3; e++) begin
      sb_q.push_back(4'b0000);
      cycle(1'b0, 1'b0, 1'b0);
      got = observed();
      checks++;
      if (got !== sb_q.pop_front()) begin
        errors++;
        $display("FAIL reset_release edge %0d: got %b expected 0000", e, got);
      end
    end
  endtask

  task automatic test_send_expiry();
    exp_t x, got;
    do_reset();
    for (int e = 0; e <= 40; e++) begin
      x = {1'b0, (e >= 15), 1'b0, (e >= 10 && e <= 14)};
      sb_q.push_back(x);
      cycle(1'b0, (e == 10), 1'b0);
      got = observed();
      x   = sb_q.pop_front();
      checks++;
      if (got !== x) begin
        errors++;
        $display("FAIL send_expiry edge %0d: got %b expected %b", e, got, x);
      end
    end
  endtask

  task automatic test_hb_retrigger();
    exp_t x, got;
    do_reset();
    for (int e = 0; e <= 40; e++) begin
      x = {(e >= 32), 1'b0, (e <= 31), 1'b0};
      sb_q.push_back(x);
      cycle((e == 0 || e == 12), 1'b0, 1'b0);
      got = observed();
      x   = sb_q.pop_front();
      checks++;
      if (got !== x) begin
        errors++;
        $display("FAIL hb_retrigger edge %0d: got %b expected %b", e, got, x);
      end
    end
  endtask

  task automatic test_coincident();
    exp_t x, got;
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      x = {1'b0, (e >= 20), 1'b0, (e >= 10 && e <= 19)};
      sb_q.push_back(x);
      cycle(1'b0, (e == 10 || e == 15), 1'b0);
      got = observed();
      x   = sb_q.pop_front();
      checks++;
      if (got !== x) begin
        errors++;
        $display("FAIL coincident_start edge %0d: got %b expected %b", e, got, x);
      end
    end
  endtask

  task automatic test_clear();
    exp_t x, got;
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      x = {1'b0, 1'b0, (e <= 2), (e <= 2)};
      sb_q.push_back(x);
      // A start arriving with the clear must lose to it.
      cycle((e == 0), (e == 0 || e == 3), (e == 3));
      got = observed();
      x   = sb_q.pop_front();
      checks++;
      if (got !== x) begin
        errors++;
        $display("FAIL timers_clear edge %0d: got %b expected %b", e, got, x);
      end
    end
  endtask

  task automatic test_mask();
    exp_t x, got;
    do_reset();
    for (int e = 0; e <= 20; e++) begin
      x = {1'b0, ((e >= 5 && e <= 9) || e >= 15), 1'b0,
           (e <= 4 || (e >= 10 && e <= 14))};
      sb_q.push_back(x);
      if (e == 10) begin
        start_hb_send_timer = 1'b1;
        #1;
        checks++;
        if (hb_send_timer_done !== 1'b0) begin
          errors++;
          $display("FAIL done_mask: got %b expected 0", hb_send_timer_done);
        end
      end
      cycle(1'b0, (e == 0 || e == 10), 1'b0);
      got = observed();
      x   = sb_q.pop_front();
      checks++;
      if (got !== x) begin
        errors++;
        $display("FAIL mask_restart edge %0d: got %b expected %b", e, got, x);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t got;
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (hb_timer_running !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_running: got %b expected 1", hb_timer_running);
    end
    #2;
    reset = 1'b1;
    #1;
    got = observed();
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b expected 0000", got);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int e = 0; e < 40; e++) begin
      sb_q.push_back(4'b0000);
      cycle(1'b0, 1'b0, 1'b0);
      got = observed();
      checks++;
      if (got !== sb_q.pop_front()) begin
        errors++;
        $display("FAIL async_reset_quiet edge %0d: got %b expected 0000", e, got);
      end
    end
  endtask

  initial begin
    test_reset();
    test_send_expiry();
    test_hb_retrigger();
    test_coincident();
    test_clear();
    test_mask();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
